// File: rtl/video_mode_pkg.sv
// ----------------------------------------------------------------------------
// video_mode_pkg
// Shared types and constants for the Dreamcast capture mode sequencer:
//   - controller state encoding
//   - mode_id codes reported to the scaler / HDMI side
//   - signature and watchdog widths
//   - mode decode helper
// ----------------------------------------------------------------------------
package video_mode_pkg;

    typedef enum logic [1:0] {
        ST_NOSIG   = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_SCAN    = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam logic [2:0] MODE_480I = 3'd0;
    localparam logic [2:0] MODE_240P = 3'd1;
    localparam logic [2:0] MODE_576I = 3'd2;
    localparam logic [2:0] MODE_288P = 3'd3;
    localparam logic [2:0] MODE_VGA  = 3'd4;

    localparam int unsigned SIG_W     = 15;
    localparam int unsigned TIMEOUT_W = 27;

    // Without the line doubler the source is VGA; otherwise the PAL and
    // add_line flags map directly onto the 480i/240p/576i/288p codes.
    function automatic logic [2:0] decode_mode(input logic line_doubler,
                                               input logic is_pal,
                                               input logic add_line);
        if (!line_doubler) begin
            return MODE_VGA;
        end
        return {1'b0, is_pal, add_line};
    endfunction

endpackage

// File: rtl/frame_watchdog.sv
// ----------------------------------------------------------------------------
// frame_watchdog
// Detects falling edges of the raw active-low vsync, produces a one-cycle
// delayed frame tick, and flags loss of signal when no edge is seen for
// TIMEOUT_CYCLES clocks.
//
// Ports:
//   i_clk      capture clock
//   i_rst_n    asynchronous active-low reset
//   i_vsync_n  raw active-low vsync, synchronous to i_clk
//   i_enable   allow the timeout flag (deasserted while already in no-signal)
//   o_tick_d   vsync falling edge delayed by one cycle
//   o_timeout  one-cycle loss-of-signal indication (combinational)
// ----------------------------------------------------------------------------
module frame_watchdog
    import video_mode_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 108_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_vsync_n,
    input  logic i_enable,
    output logic o_tick_d,
    output logic o_timeout
);

    localparam logic [TIMEOUT_W-1:0] LP_CNT_MAX  = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_W-1:0] LP_CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic                 r_vsync_q;
    logic                 r_tick_d;
    logic [TIMEOUT_W-1:0] r_count;
    logic                 w_edge;

    assign w_edge = r_vsync_q & ~i_vsync_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vsync_q <= 1'b0;
            r_tick_d  <= 1'b0;
            r_count   <= '0;
        end else begin
            r_vsync_q <= i_vsync_n;
            r_tick_d  <= w_edge;
            if (w_edge) begin
                r_count <= '0;
            end else if (r_count != LP_CNT_MAX) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // The counter saturates one past the last value, so the flag fires once
    // per silence period; an edge in the same cycle suppresses it.
    assign o_tick_d  = r_tick_d;
    assign o_timeout = i_enable & ~w_edge & (r_count == LP_CNT_LAST);

endmodule

// File: rtl/video_mode_ctrl.sv
// ----------------------------------------------------------------------------
// video_mode_ctrl
// Sequences the capture datapath: chooses generated vs live timing, holds the
// HDMI side in reset until the video mode is stable for LOCK_FRAMES frames,
// then runs a SCAN_FRAMES-long non-black-pixel scan to produce a crop window.
//
// Ports:
//   clock                  capture clock shared with the datapath
//   reset                  asynchronous active-low reset
//   _vsync                 raw active-low vsync
//   timing_info            {raw_counterX, raw_counterY}
//   add_line/is_pal/resync mode status from the datapath
//   line_doubler_cfg       user line-doubler setting
//   rescan_req             single-cycle crop rescan request
//   non_black_pos1/2       scan results from the datapath
//   line_doubler           registered line_doubler_cfg
//   generate_timing        forces free-running timing in the datapath
//   non_black_pixel_reset  one-cycle scan clear pulse
//   output_hold            holds the HDMI side in reset
//   mode_valid / mode_id   locked mode indication and code
//   crop_start/crop_end    crop window, crop_valid marks a real scan result
// ----------------------------------------------------------------------------
module video_mode_ctrl
    import video_mode_pkg::*;
#(
    parameter int unsigned LOCK_FRAMES    = 4,
    parameter int unsigned SCAN_FRAMES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 108_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        _vsync,
    input  logic [23:0] timing_info,
    input  logic        add_line,
    input  logic        is_pal,
    input  logic        resync,
    input  logic        line_doubler_cfg,
    input  logic        rescan_req,
    input  logic [11:0] non_black_pos1,
    input  logic [11:0] non_black_pos2,
    output logic        line_doubler,
    output logic        generate_timing,
    output logic        non_black_pixel_reset,
    output logic        output_hold,
    output logic        mode_valid,
    output logic [2:0]  mode_id,
    output logic [11:0] crop_start,
    output logic [11:0] crop_end,
    output logic        crop_valid
);

    localparam logic [3:0] LP_LOCK_LAST = 4'(LOCK_FRAMES - 1);
    localparam logic [3:0] LP_LOCK_DONE = 4'(LOCK_FRAMES);
    localparam logic [7:0] LP_SCAN_LAST = 8'(SCAN_FRAMES - 1);

    state_t           r_state;
    logic [SIG_W-1:0] r_sig_prev;
    logic [3:0]       r_stable_cnt;
    logic [7:0]       r_frame_cnt;
    logic             r_line_doubler;
    logic             r_generate_timing;
    logic             r_nbp_reset;
    logic             r_output_hold;
    logic             r_mode_valid;
    logic [2:0]       r_mode_id;
    logic [11:0]      r_crop_start;
    logic [11:0]      r_crop_end;
    logic             r_crop_valid;

    logic             w_tick_d;
    logic             w_timeout;
    logic [SIG_W-1:0] w_sig;
    logic             w_match;
    logic             w_drop;
    logic             w_non_black;
    logic             w_unused_counter_x;

    // raw_counterX does not take part in the frame signature.
    assign w_unused_counter_x = ^timing_info[23:12];

    frame_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk     (clock),
        .i_rst_n   (reset),
        .i_vsync_n (_vsync),
        .i_enable  (r_state != ST_NOSIG),
        .o_tick_d  (w_tick_d),
        .o_timeout (w_timeout)
    );

    assign w_sig       = {r_line_doubler, is_pal, add_line, timing_info[11:0]};
    assign w_match     = (w_sig == r_sig_prev) && !resync;
    assign w_drop      = w_tick_d && !w_match &&
                         ((r_state == ST_SCAN) || (r_state == ST_LOCKED));
    assign w_non_black = (non_black_pos1 <= non_black_pos2);

    // Priority: timeout, then loss of lock (mismatch), then rescan, then the
    // per-state frame counting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state           <= ST_NOSIG;
            r_sig_prev        <= '0;
            r_stable_cnt      <= '0;
            r_frame_cnt       <= '0;
            r_line_doubler    <= 1'b0;
            r_generate_timing <= 1'b1;
            r_nbp_reset       <= 1'b0;
            r_output_hold     <= 1'b1;
            r_mode_valid      <= 1'b0;
            r_mode_id         <= MODE_480I;
            r_crop_start      <= '0;
            r_crop_end        <= '0;
            r_crop_valid      <= 1'b0;
        end else begin
            r_line_doubler <= line_doubler_cfg;
            r_nbp_reset    <= 1'b0;
            if (w_tick_d) begin
                r_sig_prev <= w_sig;
            end

            if (w_timeout) begin
                r_state           <= ST_NOSIG;
                r_stable_cnt      <= '0;
                r_frame_cnt       <= '0;
                r_generate_timing <= 1'b1;
                r_output_hold     <= 1'b1;
                r_mode_valid      <= 1'b0;
                r_crop_valid      <= 1'b0;
            end else if (w_drop) begin
                r_state       <= ST_ACQUIRE;
                r_stable_cnt  <= '0;
                r_frame_cnt   <= '0;
                r_output_hold <= 1'b1;
                r_mode_valid  <= 1'b0;
                r_crop_valid  <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_NOSIG: begin
                        if (w_tick_d) begin
                            r_state           <= ST_ACQUIRE;
                            r_generate_timing <= 1'b0;
                            r_stable_cnt      <= '0;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (w_tick_d) begin
                            if (!w_match) begin
                                r_stable_cnt <= '0;
                            end else if (r_stable_cnt == LP_LOCK_LAST) begin
                                r_stable_cnt  <= LP_LOCK_DONE;
                                r_frame_cnt   <= '0;
                                r_mode_id     <= decode_mode(r_line_doubler, is_pal, add_line);
                                r_mode_valid  <= 1'b1;
                                r_output_hold <= 1'b0;
                                r_nbp_reset   <= 1'b1;
                                r_state       <= ST_SCAN;
                            end else begin
                                r_stable_cnt <= r_stable_cnt + 1'b1;
                            end
                        end
                    end
                    ST_SCAN: begin
                        if (w_tick_d) begin
                            if (r_frame_cnt == LP_SCAN_LAST) begin
                                r_frame_cnt <= '0;
                                r_state     <= ST_LOCKED;
                                if (w_non_black) begin
                                    r_crop_start <= non_black_pos1;
                                    r_crop_end   <= non_black_pos2;
                                    r_crop_valid <= 1'b1;
                                end else begin
                                    r_crop_start <= '0;
                                    r_crop_end   <= '0;
                                    r_crop_valid <= 1'b0;
                                end
                            end else begin
                                r_frame_cnt <= r_frame_cnt + 1'b1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (rescan_req) begin
                            r_nbp_reset <= 1'b1;
                            r_frame_cnt <= '0;
                            r_state     <= ST_SCAN;
                        end
                    end
                    default: begin
                        r_state <= ST_NOSIG;
                    end
                endcase
            end
        end
    end

    assign line_doubler          = r_line_doubler;
    assign generate_timing       = r_generate_timing;
    assign non_black_pixel_reset = r_nbp_reset;
    assign output_hold           = r_output_hold;
    assign mode_valid            = r_mode_valid;
    assign mode_id               = r_mode_id;
    assign crop_start            = r_crop_start;
    assign crop_end              = r_crop_end;
    assign crop_valid            = r_crop_valid;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// ----------------------------------------------------------------------------
// tb_video_mode_ctrl
// Directed bench for video_mode_ctrl with small lock/scan/timeout parameters.
// Frames are FRAME clocks long; vsync falls at the start of each frame.
// ----------------------------------------------------------------------------
module tb_video_mode_ctrl;

    localparam int unsigned LOCK  = 4;
    localparam int unsigned SCANF = 8;
    localparam int unsigned TMO   = 200;
    localparam int unsigned FRAME = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        _vsync = 1'b1;
    logic [23:0] timing_info;
    logic        add_line, is_pal, resync, line_doubler_cfg, rescan_req;
    logic [11:0] non_black_pos1, non_black_pos2;
    logic        line_doubler, generate_timing, non_black_pixel_reset;
    logic        output_hold, mode_valid, crop_valid;
    logic [2:0]  mode_id;
    logic [11:0] crop_start, crop_end;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned pulse_cnt = 0;
    logic        s_p0, s_p1;

    always #5 clock = ~clock;

    video_mode_ctrl #(
        .LOCK_FRAMES   (LOCK),
        .SCAN_FRAMES   (SCANF),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        ._vsync                (_vsync),
        .timing_info           (timing_info),
        .add_line              (add_line),
        .is_pal                (is_pal),
        .resync                (resync),
        .line_doubler_cfg      (line_doubler_cfg),
        .rescan_req            (rescan_req),
        .non_black_pos1        (non_black_pos1),
        .non_black_pos2        (non_black_pos2),
        .line_doubler          (line_doubler),
        .generate_timing       (generate_timing),
        .non_black_pixel_reset (non_black_pixel_reset),
        .output_hold           (output_hold),
        .mode_valid            (mode_valid),
        .mode_id               (mode_id),
        .crop_start            (crop_start),
        .crop_end              (crop_end),
        .crop_valid            (crop_valid)
    );

    always @(posedge clock) begin
        if (reset === 1'b1 && non_black_pixel_reset === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One frame: vsync low for two clocks. s_p0 samples the scan pulse in the
    // cycle the state update lands, s_p1 one cycle later. rescan_req, when
    // requested, is held for exactly the tick_d cycle.
    task automatic frame(input logic rescan);
        @(negedge clock) _vsync = 1'b0;
        @(negedge clock) if (rescan) rescan_req = 1'b1;
        @(negedge clock) begin
            rescan_req = 1'b0;
            _vsync     = 1'b1;
            s_p0       = non_black_pixel_reset;
        end
        @(negedge clock) s_p1 = non_black_pixel_reset;
        repeat (FRAME - 4) @(negedge clock);
    endtask

    task automatic frames(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) frame(1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL time_limit: observed timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset            = 1'b1;
        line_doubler_cfg = 1'b1;
        timing_info      = {12'd857, 12'd524};
        add_line         = 1'b0;
        is_pal           = 1'b0;
        resync           = 1'b0;
        rescan_req       = 1'b0;
        non_black_pos1   = 12'd0;
        non_black_pos2   = 12'd0;
        #1 reset = 1'b0;

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_gen",   generate_timing, 1);
        chk("rst_hold",  output_hold, 1);
        chk("rst_valid", mode_valid, 0);
        chk("rst_id",    mode_id, 0);
        chk("rst_cv",    crop_valid, 0);
        chk("rst_ld",    line_doubler, 0);
        chk("rst_nbp",   non_black_pixel_reset, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("ld_follow", line_doubler, 1);

        // No vsync for longer than the timeout: stays in no-signal
        repeat (TMO + 50) @(negedge clock);
        chk("nosig_gen",  generate_timing, 1);
        chk("nosig_hold", output_hold, 1);

        // First vsync fall: generate_timing drops two cycles later
        @(negedge clock) _vsync = 1'b0;
        @(negedge clock) chk("gen_fall_p1", generate_timing, 1);
        @(negedge clock) begin
            _vsync = 1'b1;
            chk("gen_fall_p2", generate_timing, 0);
        end
        repeat (FRAME - 3) @(negedge clock);

        // 480i: lock on the fourth matching frame
        frames(LOCK - 1);
        chk("prelock_hold",  output_hold, 1);
        chk("prelock_valid", mode_valid, 0);
        frame(1'b0);
        chk("lock_valid", mode_valid, 1);
        chk("lock_hold",  output_hold, 0);
        chk("lock_id",    mode_id, 0);
        chk("lock_pulse_cnt", pulse_cnt, 1);
        chk("lock_pulse_hi",  s_p0, 1);
        chk("lock_pulse_lo",  s_p1, 0);

        // Scan with a real window
        non_black_pos1 = 12'd40;
        non_black_pos2 = 12'd679;
        frames(SCANF - 1);
        chk("scan_pending_cv", crop_valid, 0);
        frame(1'b0);
        chk("crop_start", crop_start, 40);
        chk("crop_end",   crop_end, 679);
        chk("crop_valid", crop_valid, 1);

        // Rescan from LOCKED, all-black result
        non_black_pos1 = 12'd4095;
        non_black_pos2 = 12'd0;
        frame(1'b1);
        chk("rescan_pulse_cnt", pulse_cnt, 2);
        chk("rescan_pulse_hi",  s_p0, 1);
        frames(SCANF);
        chk("black_cv",    crop_valid, 0);
        chk("black_start", crop_start, 0);
        chk("black_end",   crop_end, 0);
        chk("black_valid", mode_valid, 1);

        // resync together with rescan: mismatch wins, no scan pulse
        resync = 1'b1;
        frame(1'b1);
        resync = 1'b0;
        chk("resync_pulse_cnt", pulse_cnt, 2);
        chk("resync_hold",  output_hold, 1);
        chk("resync_valid", mode_valid, 0);
        frames(LOCK - 1);
        chk("relock_pre", mode_valid, 0);
        frame(1'b0);
        chk("relock_valid", mode_valid, 1);
        chk("relock_id",    mode_id, 0);
        chk("relock_pulse_cnt", pulse_cnt, 3);

        non_black_pos1 = 12'd100;
        non_black_pos2 = 12'd200;
        frames(SCANF);
        chk("crop2_valid", crop_valid, 1);
        chk("crop2_start", crop_start, 100);

        // Mode change to 288p: drop lock, crop retained but invalid
        is_pal      = 1'b1;
        add_line    = 1'b1;
        timing_info = {12'd863, 12'd312};
        frame(1'b0);
        chk("chg_hold",  output_hold, 1);
        chk("chg_valid", mode_valid, 0);
        chk("chg_cv",    crop_valid, 0);
        chk("chg_start", crop_start, 100);
        chk("chg_end",   crop_end, 200);
        frames(LOCK - 1);
        chk("p288_pre", mode_valid, 0);
        frame(1'b0);
        chk("p288_valid", mode_valid, 1);
        chk("p288_id",    mode_id, 3);
        chk("p288_hold",  output_hold, 0);
        chk("p288_pulse_cnt", pulse_cnt, 4);

        // Asynchronous reset mid-scan
        frames(3);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_gen",   generate_timing, 1);
        chk("mid_rst_hold",  output_hold, 1);
        chk("mid_rst_valid", mode_valid, 0);
        chk("mid_rst_id",    mode_id, 0);
        chk("mid_rst_start", crop_start, 0);
        chk("mid_rst_end",   crop_end, 0);
        chk("mid_rst_cv",    crop_valid, 0);
        chk("mid_rst_ld",    line_doubler, 0);
        chk("mid_rst_nbp",   non_black_pixel_reset, 0);
        @(negedge clock) reset = 1'b1;

        // Timeout boundary: fires exactly TMO cycles after the last edge
        @(negedge clock) _vsync = 1'b0;
        @(negedge clock);
        @(negedge clock) begin
            _vsync = 1'b1;
            chk("to_acq_gen", generate_timing, 0);
        end
        repeat (TMO - 2) @(negedge clock);
        chk("to_edge_minus1", generate_timing, 0);
        @(negedge clock);
        chk("to_gen",  generate_timing, 1);
        chk("to_hold", output_hold, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
